blink_bank_mmu: RTL and testbench

//  Parametrised Blink memory-management unit between the tv80s core and external memory.

---
 rtl/blink_bank_mmu_if.sv | 32 +++
 rtl/blink_bank_mmu.sv | 106 ++++++++++
 tb/tb_blink_bank_mmu.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/blink_bank_mmu_if.sv
// blink_bank_mmu_if: CPU-side bus and memory-side selects of the Blink MMU
//  master: drives cpu_a/cpu_do/cpu_mreq_n/cpu_iorq_n/cpu_rd_n/cpu_wr_n/cpu_m1_n
//  slave : drives phys_a/rom_cs_n/ram_cs_n/card_cs_n/mem_oe_n/mem_we_n/cpu_wait_n/io_do/io_hit/com_q
interface blink_bank_mmu_if #(
  parameter int BANK_W = 8
);
  logic [15:0]        cpu_a;
  logic [7:0]         cpu_do;
  logic               cpu_mreq_n;
  logic               cpu_iorq_n;
  logic               cpu_rd_n;
  logic               cpu_wr_n;
  logic               cpu_m1_n;
  logic [BANK_W+13:0] phys_a;
  logic               rom_cs_n;
  logic               ram_cs_n;
  logic [2:0]         card_cs_n;
  logic               mem_oe_n;
  logic               mem_we_n;
  logic               cpu_wait_n;
  logic [7:0]         io_do;
  logic               io_hit;
  logic [7:0]         com_q;
  modport master (
    output cpu_a, cpu_do, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n,
    input  phys_a, rom_cs_n, ram_cs_n, card_cs_n, mem_oe_n, mem_we_n, cpu_wait_n, io_do, io_hit, com_q
  );
  modport slave (
    input  cpu_a, cpu_do, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n,
    output phys_a, rom_cs_n, ram_cs_n, card_cs_n, mem_oe_n, mem_we_n, cpu_wait_n, io_do, io_hit, com_q
  );
endinterface

// File: rtl/blink_bank_mmu.sv
// blink_bank_mmu: Blink bank mapping, region decode, wait-state insertion and bank register I/O
//  clk     in  system clock
//  reset_n in  synchronous active-low reset
//  bus     slave side of blink_bank_mmu_if (CPU strobes in; phys address, selects, wait, I/O readback out)
module blink_bank_mmu #(
  parameter int         BANK_W   = 8,
  parameter int         NUM_SEG  = 4,
  parameter logic [7:0] SR_BASE  = 8'hD0,
  parameter logic [7:0] COM_ADDR = 8'hB0,
  parameter int         ROM_WS   = 1,
  parameter int         RAM_WS   = 0,
  parameter int         CARD_WS  = 2
) (
  input logic clk,
  input logic reset_n,
  blink_bank_mmu_if.slave bus
);
  localparam int IW = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
  logic [7:0]        r_com;
  logic [7:0]        r_sr [NUM_SEG];
  logic              r_wr_prev;
  logic              r_mreq_prev;
  state_t            r_state, w_state_nx;
  logic [2:0]        r_cnt, w_cnt_nx;
  logic [7:0]        w_bank_raw;
  logic [BANK_W-1:0] w_bank;
  logic [1:0]        w_slot;
  logic              w_ram;
  logic              w_mreq;
  logic [2:0]        w_ws;
  logic              w_io_wr, w_io_rd, w_wr_pulse;
  logic              w_com_hit, w_sr_hit;
  logic [7:0]        w_sr_off;
  logic [IW-1:0]     w_idx;
  logic              w_start;
  assign w_bank_raw = bus.cpu_a[15:14] == 2'b11 ? r_sr[3] :
                      bus.cpu_a[15:14] == 2'b10 ? r_sr[2] :
                      bus.cpu_a[15:14] == 2'b01 ? r_sr[1] :
                      bus.cpu_a[13]             ? r_sr[0] :
                      r_com[2]                  ? 8'h20 : 8'h00;
  assign w_bank = BANK_W'(w_bank_raw);
  // In the lower 16K the fixed offset bit (1 for SR0, 0 for the COM bank) equals A[13]
  assign bus.phys_a = {w_bank, bus.cpu_a[13:0]};
  assign w_slot = w_bank[BANK_W-1 -: 2];
  assign w_ram  = w_bank[BANK_W-3];
  assign w_mreq = !bus.cpu_mreq_n;
  assign bus.rom_cs_n  = !(w_mreq && w_slot == 2'd0 && !w_ram);
  assign bus.ram_cs_n  = !(w_mreq && w_slot == 2'd0 && w_ram);
  assign bus.card_cs_n = ~({3{w_mreq}} & {w_slot == 2'd3, w_slot == 2'd2, w_slot == 2'd1});
  assign bus.mem_oe_n  = bus.cpu_mreq_n | bus.cpu_rd_n;
  assign bus.mem_we_n  = bus.cpu_mreq_n | bus.cpu_wr_n;
  assign w_ws = w_slot != 2'd0 ? 3'(CARD_WS) : w_ram ? 3'(RAM_WS) : 3'(ROM_WS);
  // m1_n low with iorq_n low is interrupt acknowledge, never a register access
  assign w_io_wr    = !bus.cpu_iorq_n && !bus.cpu_wr_n && bus.cpu_m1_n;
  assign w_io_rd    = !bus.cpu_iorq_n && !bus.cpu_rd_n && bus.cpu_m1_n;
  assign w_wr_pulse = w_io_wr && !r_wr_prev;
  assign w_com_hit  = bus.cpu_a[7:0] == COM_ADDR;
  assign w_sr_off   = bus.cpu_a[7:0] - SR_BASE;
  assign w_sr_hit   = int'(w_sr_off) < NUM_SEG;
  assign w_idx      = w_sr_off[IW-1:0];
  assign bus.io_hit = w_io_rd && (w_com_hit || w_sr_hit);
  assign bus.io_do  = !bus.io_hit ? 8'hFF : w_com_hit ? r_com : r_sr[w_idx];
  assign bus.com_q  = r_com;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_com       <= '0;
      r_wr_prev   <= 1'b0;
      r_mreq_prev <= 1'b1;
      for (int i = 0; i < NUM_SEG; i++) r_sr[i] <= '0;
    end else begin
      r_wr_prev   <= w_io_wr;
      r_mreq_prev <= bus.cpu_mreq_n;
      if (w_wr_pulse && w_com_hit) r_com <= bus.cpu_do;
      else if (w_wr_pulse && w_sr_hit) r_sr[w_idx] <= bus.cpu_do;
    end
  end
  // An access starts on the first clk with mreq_n low; its region (and so its wait count) is fixed there
  assign w_start = w_mreq && r_mreq_prev;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      IDLE: if (w_start) begin
        w_cnt_nx   = w_ws;
        w_state_nx = w_ws != 3'd0 ? COUNT : HOLD;
      end
      COUNT: begin
        w_cnt_nx   = r_cnt - 3'd1;
        w_state_nx = r_cnt <= 3'd1 ? HOLD : COUNT;
      end
      HOLD: w_state_nx = bus.cpu_mreq_n ? IDLE : HOLD;
      default: w_state_nx = IDLE;
    endcase
  end
  always_comb bus.cpu_wait_n = r_state != COUNT;
endmodule

// File: tb/tb_blink_bank_mmu.sv
module tb_blink_bank_mmu;
  localparam int ROM_WS = 3, RAM_WS = 0, CARD_WS = 2;
  logic clk = 0;
  logic reset_n = 0;
  int total = 0, bad = 0;
  logic [7:0] m_sr [4];
  logic [7:0] m_com;
  blink_bank_mmu_if #(.BANK_W(8)) bus ();
  blink_bank_mmu #(.BANK_W(8), .NUM_SEG(4), .SR_BASE(8'hD0), .COM_ADDR(8'hB0),
                   .ROM_WS(ROM_WS), .RAM_WS(RAM_WS), .CARD_WS(CARD_WS))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_bank(input logic [15:0] a);
    case (a[15:13])
      3'b000:          return m_com[2] ? 8'h20 : 8'h00;
      3'b001:          return m_sr[0];
      3'b010, 3'b011:  return m_sr[1];
      3'b100, 3'b101:  return m_sr[2];
      default:         return m_sr[3];
    endcase
  endfunction

  function automatic logic [21:0] m_phys(input logic [15:0] a);
    if (a[15:13] == 3'b001) return {m_sr[0], 1'b1, a[12:0]};
    if (a[15:13] == 3'b000) return {m_bank(a), 1'b0, a[12:0]};
    return {m_bank(a), a[13:0]};
  endfunction

  // 0 = ROM, 1 = RAM, 2..4 = card slot 1..3
  function automatic int m_region(input logic [7:0] b);
    return b[7:6] != 0 ? int'(b[7:6]) + 1 : int'(b[5]);
  endfunction

  function automatic int m_ws(input int r);
    return r >= 2 ? CARD_WS : r == 1 ? RAM_WS : ROM_WS;
  endfunction

  function automatic logic [2:0] m_card(input int r);
    return r == 2 ? 3'b110 : r == 3 ? 3'b101 : r == 4 ? 3'b011 : 3'b111;
  endfunction

  task automatic idle_bus();
    bus.cpu_mreq_n = 1; bus.cpu_iorq_n = 1; bus.cpu_rd_n = 1; bus.cpu_wr_n = 1; bus.cpu_m1_n = 1;
  endtask

  task automatic io_wr(input logic [7:0] port, input logic [7:0] d);
    @(negedge clk);
    bus.cpu_a = {8'($urandom), port}; bus.cpu_do = d; bus.cpu_iorq_n = 0; bus.cpu_wr_n = 0;
    @(negedge clk);
    idle_bus();
    if (port == 8'hB0) m_com = d;
    else if (port >= 8'hD0 && port <= 8'hD3) m_sr[port - 8'hD0] = d;
  endtask

  task automatic io_rd(input logic [7:0] port);
    logic hit;
    logic [7:0] d;
    hit = port == 8'hB0 || (port >= 8'hD0 && port <= 8'hD3);
    d = port == 8'hB0 ? m_com : hit ? m_sr[port - 8'hD0] : 8'hFF;
    @(negedge clk);
    bus.cpu_a = {8'($urandom), port}; bus.cpu_iorq_n = 0; bus.cpu_rd_n = 0;
    #1;
    chk($sformatf("io_hit %h", port), 32'(bus.io_hit), 32'(hit));
    chk($sformatf("io_do %h", port), 32'(bus.io_do), 32'(d));
    @(negedge clk);
    idle_bus();
  endtask

  task automatic mem(input logic [15:0] a, input logic wr);
    int r, lows;
    r = m_region(m_bank(a));
    @(negedge clk);
    bus.cpu_a = a; bus.cpu_mreq_n = 0; bus.cpu_rd_n = wr; bus.cpu_wr_n = !wr;
    #1;
    chk($sformatf("phys %h", a), 32'(bus.phys_a), 32'(m_phys(a)));
    chk("rom_cs_n", 32'(bus.rom_cs_n), 32'(r != 0));
    chk("ram_cs_n", 32'(bus.ram_cs_n), 32'(r != 1));
    chk("card_cs_n", 32'(bus.card_cs_n), 32'(m_card(r)));
    chk("mem_oe_n", 32'(bus.mem_oe_n), 32'(wr));
    chk("mem_we_n", 32'(bus.mem_we_n), 32'(!wr));
    lows = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (!bus.cpu_wait_n) lows++;
    end
    chk($sformatf("wait cycles %h", a), 32'(lows), 32'(m_ws(r)));
    @(negedge clk);
    idle_bus();
  endtask

  initial begin
    int lows;
    logic [7:0] p;
    idle_bus();
    bus.cpu_a = 0; bus.cpu_do = 0;
    m_com = 0;
    for (int i = 0; i < 4; i++) m_sr[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst wait_n", 32'(bus.cpu_wait_n), 1);
    chk("rst com_q", 32'(bus.com_q), 0);
    chk("rst rom_cs_n", 32'(bus.rom_cs_n), 1);
    chk("rst ram_cs_n", 32'(bus.ram_cs_n), 1);
    chk("rst card_cs_n", 32'(bus.card_cs_n), 3'b111);
    chk("rst io_do", 32'(bus.io_do), 8'hFF);
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 4; i++) io_rd(8'hD0 + 8'(i));
    io_wr(8'hD2, 8'h41);
    mem(16'h8123, 0);
    chk("phys 8123 literal", 32'(bus.phys_a), 22'h104123);
    io_wr(8'hB0, 8'h04);
    mem(16'h0010, 0);
    chk("phys 0010 com2", 32'(bus.phys_a), 22'h080010);
    io_wr(8'hB0, 8'h00);
    mem(16'h0010, 0);
    mem(16'h2345, 1);
    io_wr(8'hD3, 8'hC5);
    mem(16'hC000, 0);
    @(negedge clk);
    bus.cpu_a = 16'h00D1; bus.cpu_do = 8'h11; bus.cpu_iorq_n = 0; bus.cpu_wr_n = 0;
    @(negedge clk);
    @(negedge clk);
    bus.cpu_do = 8'h22;
    @(negedge clk);
    @(negedge clk);
    idle_bus();
    m_sr[1] = 8'h11;
    io_rd(8'hD1);
    mem(16'h4000, 1);
    io_wr(8'hD1, 8'h3A);
    io_rd(8'hD1);
    io_rd(8'hC7);
    @(negedge clk);
    bus.cpu_a = 16'h00D1; bus.cpu_do = 8'h99; bus.cpu_iorq_n = 0; bus.cpu_m1_n = 0;
    bus.cpu_wr_n = 0; bus.cpu_rd_n = 0;
    #1;
    chk("inta io_hit", 32'(bus.io_hit), 0);
    chk("inta io_do", 32'(bus.io_do), 8'hFF);
    @(negedge clk);
    idle_bus();
    io_rd(8'hD1);
    io_rd(8'hB0);
    @(negedge clk);
    bus.cpu_a = 16'hC0D3; bus.cpu_do = 8'h20;
    bus.cpu_mreq_n = 0; bus.cpu_rd_n = 0; bus.cpu_iorq_n = 0; bus.cpu_wr_n = 0;
    #1;
    chk("simul old phys", 32'(bus.phys_a), 22'h3140D3);
    @(posedge clk); #1;
    lows = !bus.cpu_wait_n ? 1 : 0;
    m_sr[3] = 8'h20;
    chk("simul new phys", 32'(bus.phys_a), 32'(m_phys(16'hC0D3)));
    chk("simul ram_cs_n", 32'(bus.ram_cs_n), 0);
    @(negedge clk);
    bus.cpu_iorq_n = 1; bus.cpu_wr_n = 1;
    repeat (7) begin
      @(posedge clk); #1;
      if (!bus.cpu_wait_n) lows++;
    end
    chk("simul latched ws", 32'(lows), CARD_WS);
    @(negedge clk);
    idle_bus();
    io_wr(8'hB0, 8'h00);
    @(negedge clk);
    bus.cpu_a = 16'h0010; bus.cpu_mreq_n = 0; bus.cpu_rd_n = 0;
    @(posedge clk); #1;
    chk("rom wait 1st", 32'(bus.cpu_wait_n), 0);
    @(negedge clk);
    reset_n = 0;
    @(posedge clk); #1;
    chk("midrst wait_n", 32'(bus.cpu_wait_n), 1);
    chk("midrst com_q", 32'(bus.com_q), 0);
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    reset_n = 1;
    m_com = 0;
    for (int i = 0; i < 4; i++) m_sr[i] = 0;
    io_rd(8'hD3);
    io_rd(8'hD1);
    mem(16'h0010, 0);
    repeat (60) begin
      case ($urandom_range(0, 2))
        0: begin
          p = $urandom_range(0, 5) == 5 ? 8'($urandom) : 8'($urandom_range(0, 4));
          p = p > 8'd4 ? p : p == 8'd4 ? 8'hB0 : 8'hD0 + p;
          io_wr(p, 8'($urandom));
        end
        1: mem(16'($urandom), 1'($urandom));
        default: begin
          p = $urandom_range(0, 5) == 5 ? 8'($urandom) : 8'($urandom_range(0, 4));
          p = p > 8'd4 ? p : p == 8'd4 ? 8'hB0 : 8'hD0 + p;
          io_rd(p);
        end
      endcase
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
